// File: rtl/ifft8_seq.sv
// Sequential 8-point inverse FFT: load 8 samples in bit-reversed order, run 12
// in-place radix-2 DIT butterflies (one per cycle), then stream results in natural order.
module ifft8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_real,
    input  logic [15:0] in_imag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_real,
    output logic [15:0] out_imag,
    output logic [2:0]  out_idx,
    output logic        out_last
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in LOAD, out_valid only in UNLOAD, so the two never overlap.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    localparam logic signed [15:0] TW_C = 16'sh00B4;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  in_cnt;
    logic [2:0]  out_cnt;
    logic [3:0]  bf_cnt;
    logic [15:0] mem_re [8];
    logic [15:0] mem_im [8];

    logic        in_fire;
    logic        out_fire;
    logic [1:0]  stage;
    logic [1:0]  bfly;
    logic [2:0]  top;
    logic [2:0]  bot;
    logic [1:0]  tw;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic [15:0] b_dif, b_sum;
    logic [15:0] p_re, p_im;
    logic [16:0] s_re, s_im, d_re, d_im;

    // Scale by c in Q8.8; neg negates the full product before truncation.
    function automatic logic [15:0] tw_mul(input logic [15:0] x, input logic neg);
        logic signed [31:0] prod;
        prod = 32'(TW_C) * 32'($signed(x));
        if (neg) begin
            prod = -prod;
        end
        return prod[23:8];
    endfunction

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stage    = bf_cnt[3:2];
    assign bfly     = bf_cnt[1:0];

    always_comb begin
        case (stage)
            2'd0: begin
                top = {bfly, 1'b0};
                bot = {bfly, 1'b1};
                tw  = 2'd0;
            end
            2'd1: begin
                top = {bfly[1], 1'b0, bfly[0]};
                bot = {bfly[1], 1'b1, bfly[0]};
                tw  = {bfly[0], 1'b0};
            end
            default: begin
                top = {1'b0, bfly};
                bot = {1'b1, bfly};
                tw  = bfly;
            end
        endcase
    end

    always_comb begin
        a_re  = mem_re[top];
        a_im  = mem_im[top];
        b_re  = mem_re[bot];
        b_im  = mem_im[bot];
        b_dif = b_re - b_im;
        b_sum = b_re + b_im;
        case (tw)
            2'd0: begin
                p_re = b_re;
                p_im = b_im;
            end
            2'd1: begin
                p_re = tw_mul(b_dif, 1'b0);
                p_im = tw_mul(b_sum, 1'b0);
            end
            2'd2: begin
                p_re = 16'd0 - b_im;
                p_im = b_re;
            end
            default: begin
                p_re = tw_mul(b_sum, 1'b1);
                p_im = tw_mul(b_dif, 1'b0);
            end
        endcase
        s_re = {a_re[15], a_re} + {p_re[15], p_re};
        s_im = {a_im[15], a_im} + {p_im[15], p_im};
        d_re = {a_re[15], a_re} - {p_re[15], p_re};
        d_im = {a_im[15], a_im} - {p_im[15], p_im};
    end

    // Buffer is not reset: outputs are gated by state, so stale data never escapes.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= in_real;
            mem_im[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= in_imag;
        end else if (state == COMPUTE) begin
            mem_re[top] <= s_re[16:1];
            mem_im[top] <= s_im[16:1];
            mem_re[bot] <= d_re[16:1];
            mem_im[bot] <= d_im[16:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= 3'd0;
            bf_cnt  <= 4'd0;
            out_cnt <= 3'd0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + 3'd1;
            end
            if (state == COMPUTE) begin
                bf_cnt <= (bf_cnt == 4'd11) ? 4'd0 : bf_cnt + 4'd1;
            end
            if (out_fire) begin
                out_cnt <= out_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && in_cnt == 3'd7) state_nxt = COMPUTE;
            COMPUTE: if (bf_cnt == 4'd11) state_nxt = UNLOAD;
            UNLOAD:  if (out_fire && out_cnt == 3'd7) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == UNLOAD);
        out_real  = 16'd0;
        out_imag  = 16'd0;
        out_idx   = 3'd0;
        out_last  = 1'b0;
        if (state == UNLOAD) begin
            out_real = mem_re[out_cnt];
            out_imag = mem_im[out_cnt];
            out_idx  = out_cnt;
            out_last = (out_cnt == 3'd7);
        end
    end

endmodule

// File: doc/ifft8_seq.md
IFFT8_SEQ -- requirements
Module: ifft8_seq

Interface
REQ-001 The block SHALL have no parameters; widths and the 8-point size are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  input sample present.
REQ-005 in_ready  output  1  block accepts a sample this cycle.
REQ-006 in_real, in_imag  input  16 each  frequency-domain sample X[k], signed Q8.8, k implicit in arrival order 0..7.
REQ-007 out_valid  output  1  output sample present.
REQ-008 out_ready  input  1  downstream accepts the output sample.
REQ-009 out_real, out_imag  output  16 each  time-domain sample x[n], signed Q8.8.
REQ-010 out_idx  output  3  index n of the current output sample.
REQ-011 out_last  output  1  high with the sample where out_idx=7.

Function
REQ-012 The block SHALL compute x[n] = (1/8)·Σ X[k]·W8^(-nk), the inverse of the team's 8-point FFT.
REQ-013 FSM states SHALL be LOAD, COMPUTE, UNLOAD; LOAD is the reset state.
REQ-014 LOAD: in_ready=1, out_valid=0; each in_valid&in_ready handshake writes sample k to buffer address bitrev3(k) and increments a 3-bit counter.
REQ-015 The handshake of sample 7 SHALL move the FSM to COMPUTE; in_ready SHALL be 0 outside LOAD.
REQ-016 COMPUTE: exactly one radix-2 DIT butterfly per cycle, 12 cycles total, stages s=0,1,2 in order, butterflies b=0..3 in order within each stage.
REQ-017 Butterfly addressing: half=2^s, top=(b>>s)·2·half+(b&(half-1)), bot=top+half, twiddle index t=(b&(half-1))·(4>>s).
REQ-018 Twiddle product p=W^(-t)·B: t=0 → B; t=1 → (c·(Br-Bi), c·(Br+Bi)); t=2 → (-Bi, Br); t=3 → (-c·(Br+Bi), c·(Br-Bi)); c=0x00B4.
REQ-019 Twiddle sums/differences SHALL wrap to 16 bits; multiply SHALL be signed 16x16→32 with result bits [23:8] (truncation toward -inf).
REQ-020 Butterfly outputs SHALL be A'=(A+p)>>>1 and B'=(A-p)>>>1, sums formed in 17 bits, arithmetic shift, written in place to top and bot.
REQ-021 The per-stage shift SHALL provide the full 1/8 scaling; no other scaling is applied.
REQ-022 After the 12th butterfly edge the FSM SHALL enter UNLOAD; first out_valid is high in the cycle after that edge.
REQ-023 UNLOAD: out_valid=1, outputs present buffer[n] in natural order n=0..7 with out_idx=n; n advances only on out_valid&out_ready.
REQ-024 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 The handshake with out_last=1 SHALL return the FSM to LOAD with in_ready=1 in the next cycle; input and output never overlap.
REQ-026 in_valid during COMPUTE/UNLOAD SHALL be ignored; out_ready outside UNLOAD SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force LOAD, counters to 0, in_ready=1 after release, out_valid=0, out_last=0, out_idx=0, out_real=out_imag=0.
REQ-028 Reset mid-LOAD, mid-COMPUTE or mid-UNLOAD SHALL discard the frame; buffer contents need not be cleared but SHALL never appear at outputs before a new full frame is computed.

Verification
REQ-029 Impulse: X[0]=(0x0100,0), X[1..7]=0 -> all 8 outputs (0x0020,0x0000), out_idx 0..7, out_last only on 7.
REQ-030 Bin 2: X[2]=(0x0800,0), others 0 -> x[n] real/imag = (0x0100,0),(0,0x0100),(0xFF00,0),(0,0xFF00) repeating for n=0..7, bit-exact.
REQ-031 Latency: sample 7 accepted at edge T -> out_valid first high in cycle after edge T+12; in_ready low from T+1 until the out_last handshake.
REQ-032 Backpressure: out_ready randomly low 50% during UNLOAD -> no lost/duplicated samples, outputs stable while stalled, order 0..7.
REQ-033 Reset asserted at COMPUTE cycle 5 -> out_valid=0, in_ready=1 after release; next frame (impulse) yields REQ-029 result.
REQ-034 Random frames back-to-back, inputs in ±0x0400 -> match bit-accurate model of REQ-016..021 exactly, and float IFFT within ±3 LSB.
